// File: rtl/fpu_pkg.sv
// Shared definitions for the FP issue sequencer: opcode/funct encodings,
// FPU op codes, writeback slot layout and per-op latency lookup.
package fpu_pkg;

   localparam logic [5:0] OP_FTYPE   = 6'b010001;

   localparam logic [5:0] FUNCT_ADD  = 6'b000000;
   localparam logic [5:0] FUNCT_SUB  = 6'b000001;
   localparam logic [5:0] FUNCT_MUL  = 6'b000010;
   localparam logic [5:0] FUNCT_DIV  = 6'b000011;
   localparam logic [5:0] FUNCT_ABS  = 6'b000101;
   localparam logic [5:0] FUNCT_NEG  = 6'b000111;

   localparam int LAT_ADD_DEF  = 3;
   localparam int LAT_MUL_DEF  = 4;
   localparam int LAT_DIV_DEF  = 12;
   localparam int LAT_MISC_DEF = 1;

   // Slot destination width; a larger register file needs this widened too.
   localparam int NREG_DEF  = 32;
   localparam int REG_W_DEF = $clog2(NREG_DEF);

   typedef enum logic [3:0] {
      FPU_ADD = 4'b0000,
      FPU_SUB = 4'b0001,
      FPU_MUL = 4'b0010,
      FPU_DIV = 4'b0011,
      FPU_ABS = 4'b0100,
      FPU_NEG = 4'b0101
   } fpu_op_e;

   typedef struct packed {
      logic                 valid;
      logic [REG_W_DEF-1:0] dest;
      fpu_op_e              control;
   } wb_slot_t;

   function automatic int op_latency(input fpu_op_e op,
                                     input int latAdd  = LAT_ADD_DEF,
                                     input int latMul  = LAT_MUL_DEF,
                                     input int latDiv  = LAT_DIV_DEF,
                                     input int latMisc = LAT_MISC_DEF);
      int lat;
      case (op)
         FPU_ADD, FPU_SUB: lat = latAdd;
         FPU_MUL:          lat = latMul;
         FPU_DIV:          lat = latDiv;
         default:          lat = latMisc;
      endcase
      return lat;
   endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Per-register pending-write bits for the FP register file.
// A set and a clear landing on the same register in one cycle leaves it set.
module fp_scoreboard
   import fpu_pkg::*;
#(
   parameter int NREG  = 32,
   parameter int REG_W = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             setValid_i,
   input  logic [REG_W-1:0] setReg_i,
   input  logic             clrValid_i,
   input  logic [REG_W-1:0] clrReg_i,
   output logic [NREG-1:0]  pending_o
);

   logic [NREG-1:0] pending_q, pending_d;

   always_comb begin
      pending_d = pending_q;
      if (clrValid_i) pending_d[clrReg_i] = 1'b0;
      if (setValid_i) pending_d[setReg_i] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) pending_q <= '0;
      else        pending_q <= pending_d;
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/fp_issue_sequencer.sv
// Decode-stage issue control for F-type instructions: hazard checks against
// the scoreboard, a single-port writeback slot ring and the iterative divider.
module fp_issue_sequencer
   import fpu_pkg::*;
#(
   parameter int NREG     = 32,
   parameter int REG_W    = $clog2(NREG),
   parameter int LAT_ADD  = 3,
   parameter int LAT_MUL  = 4,
   parameter int LAT_DIV  = 12,
   parameter int LAT_MISC = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic [REG_W-1:0] fs,
   input  logic [REG_W-1:0] ft,
   input  logic [REG_W-1:0] fd,
   output logic             issue_ready,
   output logic             issue_fire,
   output logic [3:0]       fpu_control,
   output logic             illegal,
   output logic             div_busy,
   output logic             wb_valid,
   output logic [REG_W-1:0] wb_reg,
   output logic [3:0]       wb_control,
   output logic [NREG-1:0]  pending
);

   localparam int MAX_AM    = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
   localparam int MAX_DM    = (LAT_DIV > LAT_MISC) ? LAT_DIV : LAT_MISC;
   localparam int MAXLAT    = (MAX_AM > MAX_DM) ? MAX_AM : MAX_DM;
   localparam int LAT_IDX_W = $clog2(MAXLAT + 1);
   localparam int DCNT_W    = $clog2(LAT_DIV + 1);

   wb_slot_t            slotRing_q [MAXLAT];
   wb_slot_t            slotRing_d [MAXLAT];
   logic [DCNT_W-1:0]   divCnt_q, divCnt_d;

   fpu_op_e             decOp;
   logic                isLegal;
   logic                isFtype;
   logic                isMisc;
   logic [LAT_IDX_W-1:0] decLat;
   logic                slotBusy;
   logic                regHazard;
   logic                divBlocked;
   logic                canIssue;
   logic                fire;

   always_comb begin
      decOp   = FPU_ADD;
      isLegal = 1'b1;
      case (funct)
         FUNCT_ADD: decOp = FPU_ADD;
         FUNCT_SUB: decOp = FPU_SUB;
         FUNCT_MUL: decOp = FPU_MUL;
         FUNCT_DIV: decOp = FPU_DIV;
         FUNCT_ABS: decOp = FPU_ABS;
         FUNCT_NEG: decOp = FPU_NEG;
         default:   isLegal = 1'b0;
      endcase
   end

   assign isFtype = (op == OP_FTYPE);
   assign isMisc  = (decOp == FPU_ABS) || (decOp == FPU_NEG);
   assign decLat  = LAT_IDX_W'(op_latency(decOp, LAT_ADD, LAT_MUL, LAT_DIV, LAT_MISC));

   // slot[L] is the entry that will reach slot[0] L cycles from now; a MAXLAT
   // op lands in slot[MAXLAT-1], which the shift always vacates.
   always_comb begin
      slotBusy = 1'b0;
      for (int k = 0; k < MAXLAT; k++)
         if (slotRing_q[k].valid && (decLat == LAT_IDX_W'(k))) slotBusy = 1'b1;
   end

   assign regHazard  = pending[fs] || pending[fd] || (!isMisc && pending[ft]);
   assign divBlocked = (decOp == FPU_DIV) && (divCnt_q != '0);
   assign canIssue   = !regHazard && !slotBusy && !divBlocked;

   assign issue_ready = !(isFtype && isLegal) || canIssue;
   assign fire        = issue_valid && isFtype && isLegal && canIssue;
   assign issue_fire  = fire;
   assign illegal     = issue_valid && isFtype && !isLegal;
   assign fpu_control = decOp;

   always_comb begin
      for (int k = 0; k < MAXLAT - 1; k++) slotRing_d[k] = slotRing_q[k+1];
      slotRing_d[MAXLAT-1] = '0;
      for (int k = 0; k < MAXLAT; k++)
         if (fire && (decLat == LAT_IDX_W'(k + 1)))
            slotRing_d[k] = '{valid: 1'b1, dest: REG_W_DEF'(fd), control: decOp};
   end

   always_comb begin
      divCnt_d = divCnt_q;
      if (fire && (decOp == FPU_DIV)) divCnt_d = DCNT_W'(LAT_DIV);
      else if (divCnt_q != '0)        divCnt_d = divCnt_q - DCNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < MAXLAT; k++) slotRing_q[k] <= '0;
         divCnt_q <= '0;
      end else begin
         for (int k = 0; k < MAXLAT; k++) slotRing_q[k] <= slotRing_d[k];
         divCnt_q <= divCnt_d;
      end
   end

   assign div_busy   = (divCnt_q != '0);
   assign wb_valid   = slotRing_q[0].valid;
   assign wb_reg     = REG_W'(slotRing_q[0].dest);
   assign wb_control = slotRing_q[0].control;

   // Writeback of slot[0] retires its destination's pending bit.
   fp_scoreboard #(
      .NREG  (NREG),
      .REG_W (REG_W)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .setValid_i (fire),
      .setReg_i   (fd),
      .clrValid_i (slotRing_q[0].valid),
      .clrReg_i   (REG_W'(slotRing_q[0].dest)),
      .pending_o  (pending)
   );

endmodule

// File: doc/fp_issue_sequencer.md
Name: fp_issue_sequencer

Overview:
- Multi-cycle issue controller for F-type (op 6'b010001) instructions in the decode stage.
- Decodes funct to an FPU op and tracks per-register pending writes (scoreboard).
- Reserves a single-port FP writeback slot per op and sequences the non-pipelined divider.
- Drives issue_ready to the hazard unit and writeback control to the FP register file.

Parameters:
- NREG, 32, number of FP registers.
- REG_W, $clog2(NREG), register index width.
- LAT_ADD, 3, add/sub latency in cycles.
- LAT_MUL, 4, multiply latency.
- LAT_DIV, 12, divide latency. Divider is iterative, one divide in flight.
- LAT_MISC, 1, abs/neg latency.
- Constraints: all latencies >= 1. MAXLAT = max of the four latencies (localparam).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low.
- issue_valid  in  1  decode holds a valid instruction.
- op  in  6  opcode.
- funct  in  6  function field.
- fs, ft, fd  in  REG_W each  source/dest FP registers.
- issue_ready  out  1  instruction may leave decode this cycle.
- issue_fire  out  1  F-type op accepted this cycle.
- fpu_control  out  4  op code for the FPU, valid when issue_fire.
- illegal  out  1  F-type with unknown funct, one-cycle pulse.
- div_busy  out  1  divider occupied.
- wb_valid  out  1  FP result writes back this cycle.
- wb_reg  out  REG_W  writeback destination.
- wb_control  out  4  op completing this cycle.
- pending  out  NREG  scoreboard bits.

Behaviour:
- Funct decode to fpu_control and latency:
  - 000000 add: 0000, LAT_ADD
  - 000001 sub: 0001, LAT_ADD
  - 000010 mul: 0010, LAT_MUL
  - 000011 div: 0011, LAT_DIV
  - 000101 abs: 0100, LAT_MISC
  - 000111 neg: 0101, LAT_MISC
- Non-F-type op: issue_ready=1, issue_fire=0, no state change.
- F-type with unknown funct: issue_ready=1, illegal=issue_valid, no state change.
- Legal F-type: issue_ready=1 only if all of:
  - pending[fs]=0 and pending[fd]=0 (RAW/WAW).
  - pending[ft]=0, except for abs/neg, which ignore ft.
  - Writeback slot free: slot[L].valid=0 for L<MAXLAT; always free when L=MAXLAT.
  - For div only, div_cnt=0.
- issue_fire = issue_valid & issue_ready & legal F-type. issue_ready is combinational from registered state.
- Slot ring: slot[0..MAXLAT-1], each holding {valid, reg, control}.
  - Every cycle, slot[k] <= slot[k+1] and slot[MAXLAT-1] clears.
  - On fire with latency L, slot[L-1] <= {1, fd, control}.
  - wb_valid/wb_reg/wb_control = slot[0], so they are registered.
- Latency: fire in cycle t produces wb_valid in cycle t+L.
- pending[fd] is set at the end of cycle t, reads 1 for cycles t+1..t+L, and is cleared at the end of cycle t+L.
  - The same register cannot be set and cleared together because issue to it is blocked while pending. RTL still gives set priority.
- Divider: div_cnt loads LAT_DIV on div fire and decrements to 0. div_busy = (div_cnt != 0).
  - Back-to-back divides are spaced at least LAT_DIV+1 cycles apart.
- Independent ops issue while a divide is in flight, subject to the scoreboard and slot checks.
- Reset (reset=0 at an edge) clears all slots, pending, and div_cnt.
  - In-flight results are dropped; no wb_valid for them.
  - All outputs read 0 the cycle after reset, except issue_ready, which is combinational and 1 for legal ops.

Decomposition:
- Package fpu_pkg:
  - OP_FTYPE constant.
  - Funct constants.
  - fpu_op_e enum (4-bit codes above).
  - wb_slot_t struct {valid, reg, control}.
  - Function op_latency(fpu_op_e).
- Sub-module fp_scoreboard (NREG, REG_W): set port, clear port, pending vector, reset, set-priority.
- Top module holds decode, slot ring, and divider counter.

Test Plan:
1. reset=0 for 2 cycles, then release -> pending=0, wb_valid=0, div_busy=0, issue_ready=1 for add.
2. add fd=1 fs=2 ft=3 fired cycle 0 -> pending[1]=1 in cycles 1-3; wb_valid=1, wb_reg=1, wb_control=0000 in cycle 3; pending[1]=0 in cycle 4.
3. RAW: add fd=1 in cycle 0, then mul fs=1 presented from cycle 1 -> issue_ready=0 in cycles 1-3; mul fires cycle 4; wb cycle 8.
4. Slot conflict: mul fd=4 cycle 0, add fd=5 presented cycle 1 -> stalled in cycle 1 (slot for cycle 4 taken), fires cycle 2, wb cycles 4 (f4) and 5 (f5).
5. Divide: div fd=6 cycle 0, div fd=7 (independent) presented cycle 1 -> div_busy cycles 1-12; wb f6 cycle 12; second div fires cycle 13; abs fd=8 presented cycle 1 fires cycle 1, wb cycle 2.
6. funct=6'b111111 -> illegal pulses 1 cycle, pending unchanged. Separately, reset=0 at cycle 5 during a div -> no wb_valid afterwards, div_busy=0.
